// File: rtl/read_ctrl_header_fsm_pkg.sv
// Shared definitions for the header-buffer read sequencer and the header register block.
package read_ctrl_header_fsm_pkg;

    localparam int unsigned LINE_W_DEF  = 2;
    localparam int unsigned CHAR_W_DEF  = 9;
    localparam int unsigned BODY_LEN_W  = 16;
    localparam int unsigned VLAN_W      = 4;
    localparam int unsigned FRAME_CNT_W = 16;

    // Last char index of a header; the header register block uses the same value.
    localparam logic [CHAR_W_DEF-1:0] TOTAL_HEADER_LENGTH_DEF = 9'd15;

    // Binary 2-bit state encoding.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HDR       = 2'd1,
        S_DESC      = 2'd2,
        S_BODY_WAIT = 2'd3
    } state_e;

    // Descriptor handed to the body reader.
    typedef struct packed {
        logic [BODY_LEN_W-1:0] body_length;
        logic [VLAN_W-1:0]     vlan;
    } desc_t;

endpackage

// File: rtl/read_ctrl_header_fsm.sv
// Read-side sequencer for the header line buffer: streams one header per line,
// hands a descriptor to the body reader and returns the line to the writer.
module read_ctrl_header_fsm
    import read_ctrl_header_fsm_pkg::*;
#(
    parameter int unsigned          LINE_W              = LINE_W_DEF,
    parameter int unsigned          CHAR_W              = CHAR_W_DEF,
    parameter logic [CHAR_W-1:0]    TOTAL_HEADER_LENGTH = CHAR_W'(TOTAL_HEADER_LENGTH_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [LINE_W-1:0]        wr_line_commit,
    input  logic                     tlast_flag,
    input  logic [BODY_LEN_W-1:0]    body_length,
    input  logic [VLAN_W-1:0]        vlan_ptr,
    output logic [LINE_W+CHAR_W-1:0] rd_ptr,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     desc_valid,
    input  logic                     desc_ready,
    output logic [BODY_LEN_W-1:0]    desc_body_length,
    output logic [VLAN_W-1:0]        desc_vlan,
    input  logic                     body_done,
    output logic                     line_release,
    output logic                     empty,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);

    state_e                 state_q, state_d;
    logic [LINE_W-1:0]      rd_line_q, rd_line_d;
    logic [CHAR_W-1:0]      rd_char_q, rd_char_d;
    desc_t                  desc_q, desc_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   line_release_q, line_release_d;
    logic                   hdr_last_c;

    // State, pointers, descriptor and counters; synchronous reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rd_line_q      <= '0;
            rd_char_q      <= '0;
            desc_q         <= '0;
            frame_cnt_q    <= '0;
            line_release_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_line_q      <= rd_line_d;
            rd_char_q      <= rd_char_d;
            desc_q         <= desc_d;
            frame_cnt_q    <= frame_cnt_d;
            line_release_q <= line_release_d;
        end
    end

    // Next-state and register updates; the char index also caps the header in case tlast_flag is late.
    always_comb begin
        state_d        = state_q;
        rd_line_d      = rd_line_q;
        rd_char_d      = rd_char_q;
        desc_d         = desc_q;
        frame_cnt_d    = frame_cnt_q;
        line_release_d = 1'b0;
        hdr_last_c     = tlast_flag || (rd_char_q == TOTAL_HEADER_LENGTH);

        case (state_q)
            S_IDLE: begin
                rd_char_d = '0;
                if (en && !empty) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (m_tready) begin
                    if (hdr_last_c) begin
                        rd_char_d          = '0;
                        desc_d.body_length = body_length;
                        desc_d.vlan        = vlan_ptr;
                        state_d            = S_DESC;
                    end else begin
                        rd_char_d = rd_char_q + CHAR_W'(1);
                    end
                end
            end
            S_DESC: begin
                if (desc_ready) begin
                    state_d = S_BODY_WAIT;
                end
            end
            S_BODY_WAIT: begin
                if (body_done) begin
                    rd_line_d      = rd_line_q + LINE_W'(1);
                    line_release_d = 1'b1;
                    frame_cnt_d    = frame_cnt_q + FRAME_CNT_W'(1);
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registers; m_tlast and empty pass through combinationally.
    assign rd_ptr           = {rd_line_q, rd_char_q};
    assign m_tvalid         = (state_q == S_HDR);
    assign m_tlast          = (state_q == S_HDR) && tlast_flag;
    assign desc_valid       = (state_q == S_DESC);
    assign desc_body_length = desc_q.body_length;
    assign desc_vlan        = desc_q.vlan;
    assign line_release     = line_release_q;
    assign empty            = (rd_line_q == wr_line_commit);
    assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_read_ctrl_header_fsm.sv
// Scoreboard bench for read_ctrl_header_fsm: a frame-level model queues the expected
// beats, descriptor and release for every committed line; a monitor checks them.
module tb_read_ctrl_header_fsm;

    localparam int unsigned CW  = 9;
    localparam int unsigned PW  = 11;
    localparam int unsigned THL = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  wr_line_commit;
    logic        tlast_flag;
    logic [15:0] body_length;
    logic [3:0]  vlan_ptr;
    logic [10:0] rd_ptr;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_body_length;
    logic [3:0]  desc_vlan;
    logic        body_done;
    logic        line_release;
    logic        empty;
    logic [15:0] frame_cnt;

    logic        bd_auto;
    logic        bd_stray;
    assign body_done = bd_auto | bd_stray;

    always #5 clk = ~clk;

    read_ctrl_header_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .wr_line_commit   (wr_line_commit),
        .tlast_flag       (tlast_flag),
        .body_length      (body_length),
        .vlan_ptr         (vlan_ptr),
        .rd_ptr           (rd_ptr),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_body_length (desc_body_length),
        .desc_vlan        (desc_vlan),
        .body_done        (body_done),
        .line_release     (line_release),
        .empty            (empty),
        .frame_cnt        (frame_cnt)
    );

    // Header register block model: per-line contents, tlast at the last char index.
    logic [15:0] line_bl [4];
    logic [3:0]  line_vl [4];
    always_comb begin
        tlast_flag  = (rd_ptr[CW-1:0] == 9'(THL));
        body_length = line_bl[rd_ptr[PW-1:CW]];
        vlan_ptr    = line_vl[rd_ptr[PW-1:CW]];
    end

    typedef struct packed { logic [10:0] ptr; logic last; } beat_t;
    typedef struct packed { logic [15:0] bl; logic [3:0] vl; } dexp_t;
    typedef struct packed { logic [15:0] cnt; logic [1:0] line; } rel_t;
    typedef struct packed { logic [7:0] id; logic [31:0] act; logic [31:0] exp; } dchk_t;

    beat_t beat_q [$];
    dexp_t desc_q [$];
    rel_t  rel_q  [$];
    dchk_t dir_q  [$];

    int tr_mode;
    int dr_mode;
    int committed;
    int model_frames;
    int chk_b2b;
    int n;
    int tgt;

    int n_cmp;
    int n_fail;
    int released;

    function automatic string dname(input logic [7:0] id);
        case (id)
            8'd1:  return "idle_tvalid";
            8'd2:  return "idle_empty";
            8'd3:  return "idle_rd_ptr";
            8'd4:  return "idle_frame_cnt";
            8'd5:  return "no_line_release";
            8'd6:  return "idle_desc_valid";
            8'd7:  return "hdr_start_latency";
            8'd8:  return "end_frame_cnt";
            8'd9:  return "end_rd_ptr";
            8'd10: return "end_empty";
            8'd11: return "desc_held_valid";
            8'd12: return "stray_hdr_release";
            8'd13: return "stray_hdr_tvalid";
            8'd14: return "stray_desc_release";
            8'd15: return "stray_desc_valid";
            8'd16: return "en_low_no_start";
            8'd17: return "rst_tvalid";
            8'd18: return "rst_rd_ptr";
            8'd19: return "rst_release";
            8'd20: return "rst_frame_cnt";
            8'd21: return "wait_timeout";
            8'd22: return "drain_timeout";
            default: return "unknown";
        endcase
    endfunction

    // Comparison primitive; only the monitor process calls it.
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic post(input int id, input logic [31:0] act, input logic [31:0] exp);
        dir_q.push_back({8'(id), act, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writer model: fill the next line and queue everything the reader must produce for it.
    task automatic commit_frame(input logic [15:0] bl, input logic [3:0] vl);
        logic [1:0] ln;
        ln = wr_line_commit;
        line_bl[ln] = bl;
        line_vl[ln] = vl;
        for (int c = 0; c <= int'(THL); c++) begin
            beat_q.push_back({ln, 9'(c), (c == int'(THL))});
        end
        desc_q.push_back({bl, vl});
        model_frames++;
        rel_q.push_back({16'(model_frames), 2'(ln + 2'd1)});
        committed++;
        wr_line_commit = 2'(ln + 2'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        beat_q.delete();
        desc_q.delete();
        rel_q.delete();
        wr_line_commit = '0;
        committed      = released;
        model_frames   = 0;
        rst = 1'b0;
    endtask

    task automatic wait_room(input int maxc);
        int k;
        k = 0;
        while ((committed - released) >= 3 && k < maxc) begin
            tick();
            k++;
        end
        post(21, 32'((committed - released) < 3), 32'd1);
    endtask

    task automatic drain(input int maxc);
        int  k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < maxc) begin
            tick();
            k++;
            ok = (beat_q.size() == 0) && (desc_q.size() == 0) && (rel_q.size() == 0)
                 && (committed == released);
        end
        post(22, 32'(ok), 32'd1);
    endtask

    // Downstream handshake drivers.
    initial begin
        m_tready   = 1'b1;
        desc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
            case (dr_mode)
                0:       desc_ready = 1'b1;
                1:       desc_ready = 1'($urandom_range(0, 1));
                default: desc_ready = 1'b0;
            endcase
        end
    end

    // Body reader model: completes the body a few cycles after taking the descriptor.
    int bd_delay;
    initial begin
        bd_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && desc_valid && desc_ready) begin
                bd_delay = $urandom_range(0, 4);
                @(posedge clk);
                repeat (bd_delay) @(posedge clk);
                #1 bd_auto = 1'b1;
                @(posedge clk);
                #1 bd_auto = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat, descriptor or release.
    beat_t       eb;
    dexp_t       ed;
    rel_t        er;
    dchk_t       dc;
    logic        p_tv, p_tr, p_dv, p_dr, b2b_pend;
    logic [10:0] p_ptr;
    logic [19:0] p_desc;
    initial begin
        n_cmp = 0; n_fail = 0; released = 0;
        p_tv = 1'b0; p_tr = 1'b0; p_dv = 1'b0; p_dr = 1'b0; b2b_pend = 1'b0;
        p_ptr = '0; p_desc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_tv = 1'b0;
                p_dv = 1'b0;
                b2b_pend = 1'b0;
            end else begin
                if (b2b_pend) chk("b2b_hdr_start", 32'(m_tvalid), 32'd1);
                b2b_pend = 1'b0;
                if (p_tv && !p_tr) begin
                    chk("stall_tvalid_hold", 32'(m_tvalid), 32'd1);
                    chk("stall_rd_ptr_hold", 32'(rd_ptr), 32'(p_ptr));
                end
                if (p_dv && !p_dr) begin
                    chk("desc_valid_hold", 32'(desc_valid), 32'd1);
                    chk("desc_stable", 32'({desc_body_length, desc_vlan}), 32'(p_desc));
                end
                if (m_tvalid && m_tready) begin
                    chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                    if (beat_q.size() != 0) begin
                        eb = beat_q.pop_front();
                        chk("beat_rd_ptr", 32'(rd_ptr), 32'(eb.ptr));
                        chk("beat_tlast", 32'(m_tlast), 32'(eb.last));
                    end
                end
                if (desc_valid && desc_ready) begin
                    chk("desc_expected", 32'(desc_q.size() != 0), 32'd1);
                    if (desc_q.size() != 0) begin
                        ed = desc_q.pop_front();
                        chk("desc_body_length", 32'(desc_body_length), 32'(ed.bl));
                        chk("desc_vlan", 32'(desc_vlan), 32'(ed.vl));
                    end
                end
                if (line_release) begin
                    released++;
                    chk("release_expected", 32'(rel_q.size() != 0), 32'd1);
                    if (rel_q.size() != 0) begin
                        er = rel_q.pop_front();
                        chk("release_frame_cnt", 32'(frame_cnt), 32'(er.cnt));
                        chk("release_rd_line", 32'(rd_ptr[10:9]), 32'(er.line));
                        chk("release_rd_char", 32'(rd_ptr[8:0]), 32'd0);
                    end
                    if (chk_b2b != 0 && (committed - released) > 0) b2b_pend = 1'b1;
                end
                p_tv   = m_tvalid;
                p_tr   = m_tready;
                p_dv   = desc_valid;
                p_dr   = desc_ready;
                p_ptr  = rd_ptr;
                p_desc = {desc_body_length, desc_vlan};
            end
            while (dir_q.size() > 0) begin
                dc = dir_q.pop_front();
                chk(dname(dc.id), dc.act, dc.exp);
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "time limit");
    end

    // Directed and random stimulus.
    initial begin
        rst = 1'b1; en = 1'b0; wr_line_commit = '0;
        tr_mode = 0; dr_mode = 0; bd_stray = 1'b0; chk_b2b = 0;
        committed = 0; model_frames = 0; n = 0; tgt = 0;
        for (int i = 0; i < 4; i++) begin
            line_bl[i] = '0;
            line_vl[i] = '0;
        end

        // Reset and idle with nothing committed.
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            post(1, 32'(m_tvalid), 32'd0);
            post(2, 32'(empty), 32'd1);
            post(3, 32'(rd_ptr), 32'd0);
            post(4, 32'(frame_cnt), 32'd0);
            post(5, 32'(line_release), 32'd0);
            post(6, 32'(desc_valid), 32'd0);
        end

        // Single frame on line 0.
        tick();
        commit_frame(16'd100, 4'h5);
        tick();
        @(negedge clk);
        post(7, 32'(m_tvalid), 32'd1);
        drain(300);
        @(negedge clk);
        post(8, 32'(frame_cnt), 32'd1);
        post(9, 32'(rd_ptr), 32'h200);
        post(10, 32'(empty), 32'd1);

        // Toggling m_tready and a descriptor held off for 10 cycles.
        tr_mode = 1;
        dr_mode = 2;
        tick();
        commit_frame(16'hBEEF, 4'hA);
        n = 0;
        while (!desc_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        post(21, 32'(desc_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            post(11, 32'(desc_valid), 32'd1);
        end
        dr_mode = 0;
        drain(300);
        tr_mode = 0;

        // Full ring and wrap: lines 0,1,2,3 back to back.
        do_reset();
        chk_b2b = 1;
        for (int k = 0; k < 4; k++) begin
            wait_room(500);
            tick();
            commit_frame(16'(200 + k), 4'(k + 1));
        end
        drain(1000);
        chk_b2b = 0;
        @(negedge clk);
        post(8, 32'(frame_cnt), 32'd4);
        post(9, 32'(rd_ptr), 32'd0);
        post(10, 32'(empty), 32'd1);

        // Stray body_done in HDR and DESC; en dropped mid-frame.
        dr_mode = 2;
        tick();
        commit_frame(16'd777, 4'h7);
        n = 0;
        while (!(m_tvalid && rd_ptr[8:0] == 9'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        post(21, 32'(m_tvalid && rd_ptr[8:0] == 9'd3), 32'd1);
        tick();
        bd_stray = 1'b1;
        en = 1'b0;
        tick();
        bd_stray = 1'b0;
        @(negedge clk);
        post(12, 32'(line_release), 32'd0);
        post(13, 32'(m_tvalid), 32'd1);
        n = 0;
        while (!desc_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        post(21, 32'(desc_valid), 32'd1);
        tick();
        bd_stray = 1'b1;
        tick();
        bd_stray = 1'b0;
        @(negedge clk);
        post(14, 32'(line_release), 32'd0);
        post(15, 32'(desc_valid), 32'd1);
        tick();
        tgt = released + 1;
        commit_frame(16'd888, 4'h8);
        dr_mode = 0;
        n = 0;
        while (released < tgt && n < 200) begin
            @(negedge clk);
            n++;
        end
        post(21, 32'(released >= tgt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            post(16, 32'(m_tvalid), 32'd0);
        end
        tick();
        en = 1'b1;
        drain(300);

        // Reset in the middle of a header.
        do_reset();
        tick();
        commit_frame(16'd1, 4'h1);
        n = 0;
        while (!(m_tvalid && rd_ptr[8:0] == 9'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        post(21, 32'(m_tvalid && rd_ptr[8:0] == 9'd7), 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        post(17, 32'(m_tvalid), 32'd0);
        post(18, 32'(rd_ptr), 32'd0);
        post(19, 32'(line_release), 32'd0);
        post(20, 32'(frame_cnt), 32'd0);
        beat_q.delete();
        desc_q.delete();
        rel_q.delete();
        wr_line_commit = '0;
        committed      = released;
        model_frames   = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            post(5, 32'(line_release), 32'd0);
            post(1, 32'(m_tvalid), 32'd0);
        end

        // Random traffic with random backpressure and body latency.
        for (int f = 0; f < 40; f++) begin
            tr_mode = $urandom_range(0, 2);
            dr_mode = $urandom_range(0, 1);
            wait_room(500);
            repeat ($urandom_range(0, 3)) tick();
            tick();
            commit_frame(16'($urandom), 4'($urandom));
        end
        tr_mode = 0;
        dr_mode = 0;
        drain(4000);
        @(negedge clk);
        post(8, 32'(frame_cnt), 32'(model_frames));
        post(9, 32'(rd_ptr), 32'({wr_line_commit, 9'd0}));
        post(10, 32'(empty), 32'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
